// File: rtl/preg_free_list_ctrl.sv
// Physical-register free list: circular buffer of free register numbers,
// self-initialised after reset, with multi-lane all-or-nothing allocate and multi-lane release.

module preg_fl_wrap_add #(
    parameter int ENTRY_NUM = 32,
    parameter int PTR_W     = 5,
    parameter int CNT_W     = 6
) (
    input  logic [PTR_W-1:0] i_base,
    input  logic [CNT_W-1:0] i_off,
    output logic [PTR_W-1:0] o_sum
);
    localparam int SUM_W = CNT_W + 1;

    logic [SUM_W-1:0] w_raw;
    logic [SUM_W-1:0] w_wrapped;

    // Compare-and-subtract rather than truncation so odd depths wrap correctly.
    assign w_raw     = SUM_W'(i_base) + SUM_W'(i_off);
    assign w_wrapped = (w_raw >= SUM_W'(ENTRY_NUM)) ? (w_raw - SUM_W'(ENTRY_NUM)) : w_raw;
    assign o_sum     = PTR_W'(w_wrapped);
endmodule

module preg_free_list_ctrl #(
    parameter int ENTRY_NUM  = 32,
    parameter int PREG_W     = 6,
    parameter int POP_WIDTH  = 2,
    parameter int PUSH_WIDTH = 2,
    parameter int INIT_BASE  = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [POP_WIDTH-1:0]                   popReq,
    output logic                                   popGrant,
    output logic [POP_WIDTH-1:0][PREG_W-1:0]       popRegNum,
    input  logic [PUSH_WIDTH-1:0]                  pushValid,
    input  logic [PUSH_WIDTH-1:0][PREG_W-1:0]      pushRegNum,
    output logic                                   ready,
    output logic [$clog2(ENTRY_NUM+1)-1:0]         freeCount,
    output logic                                   overflow
);
    localparam int CNT_W = $clog2(ENTRY_NUM + 1);
    localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
    localparam int SUM_W = CNT_W + 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [PTR_W-1:0]  r_init_idx;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_free_cnt;
    logic              r_overflow;
    logic [PREG_W-1:0] r_mem [ENTRY_NUM];

    logic                             w_run;
    logic [POP_WIDTH-1:0][CNT_W-1:0]  w_pop_rank;
    logic [PUSH_WIDTH-1:0][CNT_W-1:0] w_push_rank;
    logic [CNT_W-1:0]                 w_pop_n;
    logic [CNT_W-1:0]                 w_push_n;
    logic [POP_WIDTH-1:0][PTR_W-1:0]  w_pop_addr;
    logic [PUSH_WIDTH-1:0][PTR_W-1:0] w_push_addr;
    logic                             w_grant;
    logic [CNT_W-1:0]                 w_cnt_after_pop;
    logic [SUM_W-1:0]                 w_cnt_sum;
    logic                             w_drop;
    logic                             w_push_ok;
    logic [CNT_W-1:0]                 w_cnt_nxt;
    logic [PTR_W-1:0]                 w_head_adv;
    logic [PTR_W-1:0]                 w_tail_adv;

    assign w_run = (r_state == ST_RUN);

    // Rank of each active lane among active lanes, plus the total.
    always_comb begin
        w_pop_n = '0;
        for (int l = 0; l < POP_WIDTH; l++) begin
            w_pop_rank[l] = w_pop_n;
            w_pop_n       = w_pop_n + CNT_W'(popReq[l]);
        end
    end

    always_comb begin
        w_push_n = '0;
        for (int l = 0; l < PUSH_WIDTH; l++) begin
            w_push_rank[l] = w_push_n;
            w_push_n       = w_push_n + CNT_W'(pushValid[l]);
        end
    end

    genvar g;
    generate
        for (g = 0; g < POP_WIDTH; g++) begin : g_pop_lane
            preg_fl_wrap_add #(.ENTRY_NUM(ENTRY_NUM), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_addr (
                .i_base (r_head),
                .i_off  (w_pop_rank[g]),
                .o_sum  (w_pop_addr[g])
            );
            assign popRegNum[g] = r_mem[w_pop_addr[g]];
        end
        for (g = 0; g < PUSH_WIDTH; g++) begin : g_push_lane
            preg_fl_wrap_add #(.ENTRY_NUM(ENTRY_NUM), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_addr (
                .i_base (r_tail),
                .i_off  (w_push_rank[g]),
                .o_sum  (w_push_addr[g])
            );
        end
    endgenerate

    preg_fl_wrap_add #(.ENTRY_NUM(ENTRY_NUM), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_head_adv (
        .i_base (r_head),
        .i_off  (w_pop_n),
        .o_sum  (w_head_adv)
    );

    preg_fl_wrap_add #(.ENTRY_NUM(ENTRY_NUM), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_tail_adv (
        .i_base (r_tail),
        .i_off  (w_push_n),
        .o_sum  (w_tail_adv)
    );

    // Grant looks only at the pre-edge count; same-cycle releases cannot rescue a denied pop.
    assign w_grant         = w_run && (w_pop_n != '0) && (r_count >= w_pop_n);
    assign w_cnt_after_pop = w_grant ? (r_count - w_pop_n) : r_count;
    assign w_cnt_sum       = SUM_W'(w_cnt_after_pop) + SUM_W'(w_push_n);
    assign w_drop          = w_run && (w_cnt_sum > SUM_W'(ENTRY_NUM));
    assign w_push_ok       = w_run && !w_drop && (w_push_n != '0);
    assign w_cnt_nxt       = w_drop ? w_cnt_after_pop : CNT_W'(w_cnt_sum);

    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_init_idx] <= PREG_W'(INIT_BASE) + PREG_W'(r_init_idx);
        end else if (w_push_ok) begin
            for (int l = 0; l < PUSH_WIDTH; l++) begin
                if (pushValid[l]) r_mem[w_push_addr[l]] <= pushRegNum[l];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_idx <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_free_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (r_state == ST_INIT) begin
            if (r_init_idx == PTR_W'(ENTRY_NUM - 1)) begin
                r_state    <= ST_RUN;
                r_init_idx <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= CNT_W'(ENTRY_NUM);
                r_free_cnt <= CNT_W'(ENTRY_NUM);
            end else begin
                r_init_idx <= r_init_idx + PTR_W'(1);
            end
        end else begin
            if (w_grant)   r_head <= w_head_adv;
            if (w_push_ok) r_tail <= w_tail_adv;
            r_count    <= w_cnt_nxt;
            r_free_cnt <= w_cnt_nxt;
            if (w_drop)    r_overflow <= 1'b1;
        end
    end

    assign popGrant  = w_grant;
    assign ready     = w_run;
    assign freeCount = r_free_cnt;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_preg_free_list_ctrl.sv
// Directed + randomized bench for preg_free_list_ctrl against a queue-based free-list model.

module tb_preg_free_list_ctrl;
    localparam int EN    = 32;
    localparam int PW    = 6;
    localparam int POPW  = 2;
    localparam int PUSHW = 2;
    localparam int BASE  = 32;
    localparam int CW    = $clog2(EN + 1);

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [POPW-1:0]             popReq = '0;
    logic                        popGrant;
    logic [POPW-1:0][PW-1:0]     popRegNum;
    logic [PUSHW-1:0]            pushValid = '0;
    logic [PUSHW-1:0][PW-1:0]    pushRegNum = '0;
    logic                        ready;
    logic [CW-1:0]               freeCount;
    logic                        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: free registers in allocation order, plus init progress and sticky error.
    int fl[$];
    bit m_run;
    int m_init;
    bit m_ovf;

    always #5 clk = ~clk;

    preg_free_list_ctrl #(
        .ENTRY_NUM(EN), .PREG_W(PW), .POP_WIDTH(POPW), .PUSH_WIDTH(PUSHW), .INIT_BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .popReq(popReq), .popGrant(popGrant), .popRegNum(popRegNum),
        .pushValid(pushValid), .pushRegNum(pushRegNum),
        .ready(ready), .freeCount(freeCount), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        m_run  = 1'b0;
        m_init = 0;
        m_ovf  = 1'b0;
    endtask

    // One clock: drive after negedge, check combinational grant/data, then registered state.
    task automatic step(input logic [POPW-1:0] pr, input logic [PUSHW-1:0] pv,
                        input logic [PUSHW-1:0][PW-1:0] pn);
        int pop_n, push_n, rank, after;
        bit g;
        @(negedge clk);
        popReq = pr; pushValid = pv; pushRegNum = pn;
        #1;
        pop_n = 0; push_n = 0;
        for (int i = 0; i < POPW; i++)  if (pr[i]) pop_n++;
        for (int i = 0; i < PUSHW; i++) if (pv[i]) push_n++;
        g = m_run && (pop_n > 0) && (fl.size() >= pop_n);
        chk("popGrant", popGrant, g);
        if (g) begin
            rank = 0;
            for (int l = 0; l < POPW; l++) begin
                if (pr[l]) begin
                    chk($sformatf("popRegNum[%0d]", l), popRegNum[l], fl[rank]);
                    rank++;
                end
            end
        end
        @(posedge clk);
        if (!m_run) begin
            m_init++;
            if (m_init == EN) begin
                m_run = 1'b1;
                for (int i = 0; i < EN; i++) fl.push_back(BASE + i);
            end
        end else begin
            after = fl.size() - (g ? pop_n : 0);
            if (g) for (int i = 0; i < pop_n; i++) void'(fl.pop_front());
            if (after + push_n > EN) m_ovf = 1'b1;
            else for (int l = 0; l < PUSHW; l++) if (pv[l]) fl.push_back(int'(pn[l]));
        end
        #1;
        chk("ready", ready, m_run);
        chk("freeCount", freeCount, m_run ? fl.size() : 0);
        chk("overflow", overflow, m_ovf);
    endtask

    function automatic logic [PUSHW-1:0][PW-1:0] rand_nums();
        logic [PUSHW-1:0][PW-1:0] v;
        for (int l = 0; l < PUSHW; l++) v[l] = PW'($urandom_range(0, (1 << PW) - 1));
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0);
    endtask

    task automatic pop_to(input int target);
        int guard = 0;
        while (fl.size() > target && guard < 200) begin
            step((fl.size() - target >= 2) ? 2'b11 : 2'b01, '0, '0);
            guard++;
        end
    endtask

    task automatic fill_to(input int target);
        int guard = 0;
        while (fl.size() < target && guard < 200) begin
            step('0, (target - fl.size() >= 2) ? 2'b11 : 2'b01, rand_nums());
            guard++;
        end
    endtask

    // Async reset asserted between edges with a pop request pending.
    task automatic async_reset();
        @(negedge clk);
        popReq = 2'b11; pushValid = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst.ready", ready, 1'b0);
        chk("rst.popGrant", popGrant, 1'b0);
        chk("rst.freeCount", freeCount, 0);
        chk("rst.overflow", overflow, 1'b0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        popReq = '0;
    endtask

    initial begin
        logic [PUSHW-1:0][PW-1:0] pn;
        model_reset();
        popReq = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("por.ready", ready, 1'b0);
        chk("por.popGrant", popGrant, 1'b0);
        chk("por.freeCount", freeCount, 0);
        chk("por.overflow", overflow, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        popReq = '0;

        // Init sequence, then first allocations
        idle(EN + 1);
        step(2'b11, '0, '0);
        step(2'b01, '0, '0);

        // Low-count denial with a same-cycle release
        pop_to(1);
        pn = '0; pn[0] = PW'(40);
        step(2'b11, 2'b01, pn);
        step(2'b11, '0, '0);
        step(2'b01, '0, '0);
        step(2'b10, '0, '0);

        // Release into a full list
        fill_to(EN);
        step(2'b01, 2'b11, rand_nums());
        idle(2);
        step(2'b00, 2'b11, rand_nums());

        // Steady-state pop2/push2, pointers wrap repeatedly
        for (int i = 0; i < 100; i++) step(2'b11, 2'b11, rand_nums());

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(POPW'($urandom_range(0, 3)), PUSHW'($urandom_range(0, 3)), rand_nums());

        // Reset mid-run with ten free entries
        if (fl.size() > 10) pop_to(10); else fill_to(10);
        async_reset();
        idle(5);

        // Reset mid-init, then a full init and drain of fresh contents
        async_reset();
        idle(EN + 1);
        pop_to(0);
        step(2'b01, '0, '0);
        fill_to(3);
        pop_to(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
